// File: rtl/dynamic_branch_predictor_if.sv
// rtl/dynamic_branch_predictor_if.sv - fetch/execute bundle for the bimodal branch predictor
//
// Purpose : groups the fetch-side decode/predict signals, the execute-side
//           training strobe and the statistics outputs of the predictor.
// Signals : fetch_pc, instruction                 -> predictor (fetch)
//           branch_prediction, JALR, is_cond_branch <- predictor (fetch)
//           update_valid/pc/taken/predicted       -> predictor (execute)
//           branch_count, mispredict_count        <- predictor (stats)
// Modports: master = pipeline side, slave = predictor side.
interface dynamic_branch_predictor_if #(
    parameter int size   = 32,
    parameter int STAT_W = 32
);
    logic [size-1:0]   fetch_pc;
    logic [size-1:0]   instruction;
    logic              branch_prediction;
    logic              JALR;
    logic              is_cond_branch;
    logic              update_valid;
    logic [size-1:0]   update_pc;
    logic              update_taken;
    logic              update_predicted;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] mispredict_count;

    modport master (
        output fetch_pc, instruction,
        output update_valid, update_pc, update_taken, update_predicted,
        input  branch_prediction, JALR, is_cond_branch,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  fetch_pc, instruction,
        input  update_valid, update_pc, update_taken, update_predicted,
        output branch_prediction, JALR, is_cond_branch,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/dynamic_branch_predictor.sv
// rtl/dynamic_branch_predictor.sv - bimodal branch predictor with saturating counter table and stats
//
// Purpose : decodes JAL/JALR/conditional branch from the fetched word, predicts
//           conditional branches from a PC-indexed table of saturating counters,
//           trains that table from resolved-branch updates and keeps saturating
//           branch / mispredict statistics.
// Ports   : clk   - clock, all state changes on the rising edge
//           reset - synchronous active-high reset (wins over a same-cycle update)
//           bp    - dynamic_branch_predictor_if.slave (fetch, update and stats signals)
module dynamic_branch_predictor #(
    parameter int size      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_W     = 2,
    parameter int CTR_INIT  = 1,
    parameter int STAT_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    dynamic_branch_predictor_if.slave     bp
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    localparam logic [CTR_W-1:0]  CTR_MAX   = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_RST   = CTR_W'(CTR_INIT);
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

    logic [CTR_W-1:0]  r_bht [BHT_DEPTH];
    logic [STAT_W-1:0] r_branch_count;
    logic [STAT_W-1:0] r_mispredict_count;

    logic [4:0]       w_opc;
    logic             w_is_jal;
    logic             w_is_branch;
    logic             w_is_jalr;
    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [CTR_W-1:0] w_upd_ctr;
    logic             w_unused;

    assign w_opc       = bp.instruction[6:2];
    assign w_is_jal    = (w_opc == OPC_JAL);
    assign w_is_branch = (w_opc == OPC_BRANCH);
    assign w_is_jalr   = (w_opc == OPC_JALR);

    // Word-aligned PCs: bits [1:0] never select an entry; higher bits alias.
    assign w_fetch_idx = bp.fetch_pc[IDX_W+1:2];
    assign w_upd_idx   = bp.update_pc[IDX_W+1:2];
    assign w_upd_ctr   = r_bht[w_upd_idx];

    // Fetch reads the table as registered, so a same-cycle update is not bypassed.
    assign bp.branch_prediction = w_is_jal | (w_is_branch & r_bht[w_fetch_idx][CTR_W-1]);
    assign bp.JALR              = w_is_jalr;
    assign bp.is_cond_branch    = w_is_branch;
    assign bp.branch_count      = r_branch_count;
    assign bp.mispredict_count  = r_mispredict_count;

    assign w_unused = ^{bp.instruction[size-1:7], bp.instruction[1:0],
                        bp.fetch_pc[size-1:IDX_W+2], bp.fetch_pc[1:0],
                        bp.update_pc[size-1:IDX_W+2], bp.update_pc[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= CTR_RST;
            end
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (bp.update_valid) begin
            if (bp.update_taken) begin
                if (w_upd_ctr != CTR_MAX) begin
                    r_bht[w_upd_idx] <= w_upd_ctr + 1'b1;
                end
            end else begin
                if (w_upd_ctr != '0) begin
                    r_bht[w_upd_idx] <= w_upd_ctr - 1'b1;
                end
            end
            if (r_branch_count != STAT_MAX) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
            if ((bp.update_predicted != bp.update_taken) && (r_mispredict_count != STAT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// tb/tb_dynamic_branch_predictor.sv - directed vector bench for dynamic_branch_predictor
module tb_dynamic_branch_predictor;
    localparam logic [31:0] I_BR   = 32'h0000_0063;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_0067;
    localparam logic [31:0] I_NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    always #5 clk = ~clk;

    dynamic_branch_predictor_if #(.size(32), .STAT_W(32)) bif ();
    dynamic_branch_predictor_if #(.size(32), .STAT_W(3))  bif2 ();

    dynamic_branch_predictor #(.size(32), .BHT_DEPTH(64), .CTR_W(2), .CTR_INIT(1), .STAT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bif.slave)
    );

    dynamic_branch_predictor #(.size(32), .BHT_DEPTH(64), .CTR_W(2), .CTR_INIT(1), .STAT_W(3)) dut_s (
        .clk   (clk),
        .reset (reset2),
        .bp    (bif2.slave)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        up;
        logic        e_pred;
        logic        e_jalr;
        logic        e_cond;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                                input logic uv, input logic [31:0] upc, input logic ut, input logic up,
                                input logic e_pred, input logic e_jalr, input logic e_cond,
                                input logic [31:0] e_bc, input logic [31:0] e_mc);
        vec_t v;
        v.rst = rst; v.pc = pc; v.instr = instr; v.uv = uv; v.upc = upc; v.ut = ut; v.up = up;
        v.e_pred = e_pred; v.e_jalr = e_jalr; v.e_cond = e_cond; v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic drive1(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                          input logic uv, input logic [31:0] upc, input logic ut, input logic up);
        reset                = rst;
        bif.fetch_pc         = pc;
        bif.instruction      = instr;
        bif.update_valid     = uv;
        bif.update_pc        = upc;
        bif.update_taken     = ut;
        bif.update_predicted = up;
    endtask

    initial begin
        // Expected values are pre-edge: outputs reflect state left by earlier rows.
        vecs.push_back(mk(0, 32'h100, I_BR,   0, 0,      0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 32'h100, I_JAL,  0, 0,      0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h100, I_JALR, 0, 0,      0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 1, 0, 0, 0, 1, 0, 0)); // same-cycle: old ctr 1
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 1, 0, 1, 0, 1, 1, 1)); // ctr 2
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 1, 0, 1, 0, 1, 2, 2)); // ctr 3
        vecs.push_back(mk(0, 32'h100, I_BR,   0, 0,      0, 0, 1, 0, 1, 3, 3)); // saturated at 3
        vecs.push_back(mk(0, 32'h104, I_BR,   0, 0,      0, 0, 0, 0, 1, 3, 3)); // isolation
        vecs.push_back(mk(0, 32'h200, I_BR,   0, 0,      0, 0, 1, 0, 1, 3, 3)); // alias of 0x100
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 0, 1, 1, 0, 1, 3, 3)); // 3 -> 2
        vecs.push_back(mk(0, 32'h100, I_BR,   0, 0,      0, 0, 1, 0, 1, 4, 4));
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 0, 1, 1, 0, 1, 4, 4)); // 2 -> 1
        vecs.push_back(mk(0, 32'h100, I_BR,   0, 0,      0, 0, 0, 0, 1, 5, 5));
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 0, 0, 0, 0, 1, 5, 5)); // correct, 1 -> 0
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 0, 0, 0, 0, 1, 6, 5)); // floor at 0
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 1, 0, 0, 0, 1, 7, 5)); // 0 -> 1
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h100, 1, 0, 0, 0, 1, 8, 6)); // 1 -> 2
        vecs.push_back(mk(0, 32'h100, I_NOP,  0, 0,      0, 0, 0, 0, 0, 9, 7));
        vecs.push_back(mk(1, 32'h100, I_BR,   1, 32'h100, 1, 0, 1, 0, 1, 9, 7)); // reset + update
        vecs.push_back(mk(0, 32'h100, I_BR,   1, 32'h200, 1, 0, 0, 0, 1, 0, 0)); // post-reset update
        vecs.push_back(mk(0, 32'h100, I_BR,   0, 0,      0, 0, 1, 0, 1, 1, 1));

        drive1(1, 0, I_NOP, 0, 0, 0, 0);
        reset2 = 1'b1;
        bif2.fetch_pc = 0; bif2.instruction = I_NOP; bif2.update_valid = 0;
        bif2.update_pc = 32'h100; bif2.update_taken = 1; bif2.update_predicted = 0;
        repeat (2) @(posedge clk);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive1(vecs[k].rst, vecs[k].pc, vecs[k].instr, vecs[k].uv, vecs[k].upc, vecs[k].ut, vecs[k].up);
            #1;
            check($sformatf("v%0d_pred", k), {31'b0, bif.branch_prediction}, {31'b0, vecs[k].e_pred});
            check($sformatf("v%0d_jalr", k), {31'b0, bif.JALR},              {31'b0, vecs[k].e_jalr});
            check($sformatf("v%0d_cond", k), {31'b0, bif.is_cond_branch},    {31'b0, vecs[k].e_cond});
            check($sformatf("v%0d_bc", k),   bif.branch_count,               vecs[k].e_bc);
            check($sformatf("v%0d_mc", k),   bif.mispredict_count,           vecs[k].e_mc);
        end

        // Reset priority across the whole table: saturate every entry, reset with an update pending.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                drive1(0, 0, I_NOP, 1, i * 4, 1, 1);
            end
        end
        @(negedge clk);
        drive1(0, 32'h40, I_BR, 0, 0, 0, 0);
        #1 check("trained_idx16", {31'b0, bif.branch_prediction}, 32'd1);
        @(negedge clk);
        drive1(1, 0, I_NOP, 1, 32'h40, 1, 0);
        @(negedge clk);
        drive1(0, 0, I_NOP, 0, 0, 0, 0);
        #1;
        check("rst_bc", bif.branch_count, 32'd0);
        check("rst_mc", bif.mispredict_count, 32'd0);
        for (int i = 0; i < 64; i++) begin
            bif.fetch_pc = 32'h1000 + i * 4;
            bif.instruction = I_BR;
            #1 check($sformatf("rst_idx%0d", i), {31'b0, bif.branch_prediction}, 32'd0);
        end
        // A single taken update must now flip entry 16, proving it sits at exactly 1.
        @(negedge clk);
        drive1(0, 32'h40, I_BR, 1, 32'h40, 1, 1);
        @(negedge clk);
        drive1(0, 32'h40, I_BR, 0, 0, 0, 0);
        #1 check("rst_ctr_is_init", {31'b0, bif.branch_prediction}, 32'd1);

        // Statistics saturation on the 3-bit instance.
        @(negedge clk);
        reset2 = 1'b0;
        #1 check("s_bc_init", {29'b0, bif2.branch_count}, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            bif2.update_valid = 1'b1;
            @(negedge clk);
            #1;
            check($sformatf("s_bc_%0d", i), {29'b0, bif2.branch_count},     (i > 7) ? 32'd7 : 32'(i));
            check($sformatf("s_mc_%0d", i), {29'b0, bif2.mispredict_count}, (i > 7) ? 32'd7 : 32'(i));
        end
        bif2.update_valid = 1'b0;
        @(negedge clk);
        #1;
        check("s_bc_hold", {29'b0, bif2.branch_count}, 32'd7);
        check("s_mc_hold", {29'b0, bif2.mispredict_count}, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dynamic_branch_predictor.md
# dynamic_branch_predictor

Parametrised bimodal branch predictor for the fetch stage, replacing the static always-taken scheme for conditional branches. Decodes the fetched instruction for JAL, JALR and conditional branch. Predicts conditional branches from a PC-indexed table of saturating counters, which is trained by resolved-branch updates from execute. Keeps saturating branch and mispredict statistics counters for performance analysis.

## Interface
- size, 32, instruction/PC width
- BHT_DEPTH, 64, number of counter entries; power of two, ≥ 2
- CTR_W, 2, saturating counter width; ≥ 1
- CTR_INIT, 1, reset value of every counter (1 = weakly not-taken for CTR_W=2); < 2^CTR_W
- STAT_W, 32, statistics counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_pc  in  size  PC of the instruction in fetch
- instruction  in  size  fetched instruction word
- branch_prediction  out  1  1 = predicted taken (JAL, or conditional branch with counter MSB set)
- JALR  out  1  fetched instruction is JALR
- is_cond_branch  out  1  fetched instruction is a conditional branch
- update_valid  in  1  resolved conditional branch presented this cycle
- update_pc  in  size  PC of the resolved branch
- update_taken  in  1  actual outcome
- update_predicted  in  1  prediction that was made for that branch in fetch
- branch_count  out  STAT_W  resolved conditional branches since reset
- mispredict_count  out  STAT_W  resolved branches with update_predicted ≠ update_taken

## Operation
- Decode uses instruction[6:2]:
  - J = 11011 (JAL).
  - B = 11000 (conditional branch).
  - JALR = 11001.
- Index: IDX_W = log2(BHT_DEPTH).
  - Fetch index = fetch_pc[IDX_W+1:2].
  - Update index = update_pc[IDX_W+1:2].
- branch_prediction = J | (B & bht[fetch_idx][CTR_W-1]). JALR is never predicted taken here; the JALR output goes to the stage that resolves the register target.
- is_cond_branch = B. branch_prediction, JALR and is_cond_branch are combinational from instruction, fetch_pc and current table state.
- Update, when update_valid=1 and reset=0:
  - Taken: the counter increments, saturating at 2^CTR_W−1.
  - Not taken: the counter decrements, saturating at 0.
- Statistics, when update_valid=1 and reset=0:
  - branch_count increments.
  - mispredict_count increments if update_predicted ≠ update_taken.
  - Both saturate at 2^STAT_W−1 and never wrap.
- Reset: all BHT_DEPTH entries are set to CTR_INIT in the single reset cycle. Both statistics counters are set to 0. Reset has priority over a simultaneous update, which is discarded.
- Reset after reset deasserts, for an ordinary conditional branch: branch_prediction = CTR_INIT MSB. With defaults this is 0, i.e. not taken.

## Timing
- Prediction latency is zero cycles (combinational in the fetch cycle).
- An update presented at edge N is visible to the fetch read and to the stats outputs after edge N.
- Same-cycle update and fetch to the same index:
  - The fetch sees the pre-update value. There is no bypass.
  - The new value is seen from the next cycle.
- Back-to-back updates to the same index on consecutive cycles accumulate. Each update reads the value written by the previous one.
- There is no handshake. update_valid is a single-cycle strobe and the block always accepts it.
- Aliasing: PCs that differ only above bit IDX_W+1 share an entry. This is intended.
- Reset mid-stream: an in-flight update in the reset cycle is dropped. Updates on the cycle after reset deasserts are applied normally.

## Test plan
- **Reset and decode.** Apply reset, then fetch the branch 0x00000063 at fetch_pc=0x100. Required: branch_prediction=0, is_cond_branch=1, branch_count=0, mispredict_count=0. Then fetch JAL 0x0000006F, which must give branch_prediction=1. Then fetch JALR 0x00000067, which must give JALR=1 and branch_prediction=0.
- **Training and saturation.** Send 3 taken updates to pc 0x100 with update_predicted=0. Required: prediction at 0x100 becomes 1 after the first update (counter 2), counter saturates at 3, branch_count=3, mispredict_count=3. Then send 1 not-taken update: prediction stays 1 (counter 2). A second not-taken update gives prediction 0.
- **Aliasing and isolation.** Train 0x100 to taken. Required: 0x104 is still not-taken, while 0x200 (same index with BHT_DEPTH=64) reads taken.
- **Same-cycle update and read.** With counter at 1, update 0x100 taken while fetching 0x100 in the same cycle. Required: branch_prediction=0 in that cycle and 1 in the next.
- **Reset priority.** With counters trained, assert reset together with update_valid=1. Required: every counter returns to CTR_INIT and the stats are 0, with no effect from the update.
- **Stats saturation.** With STAT_W=3, send 10 mispredicted updates. Required: branch_count=7 and mispredict_count=7, holding without wrap.
